// File: rtl/immediate_pack_pkg.sv
// Shared encodings for the immediate packer: imm_select codes, NOP word, field positions
// and the registered request struct carried in the first pipeline stage.
package immediate_pack_pkg;

    localparam logic [2:0] IMM_U       = 3'b000;
    localparam logic [2:0] IMM_I       = 3'b001;
    localparam logic [2:0] IMM_ISH     = 3'b010;
    localparam logic [2:0] IMM_S       = 3'b011;
    localparam logic [2:0] IMM_B       = 3'b100;
    localparam logic [2:0] IMM_J       = 3'b101;
    localparam logic [2:0] IMM_R       = 3'b110;
    localparam logic [2:0] IMM_ILLEGAL = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } pack_req_t;

    // True when v[31:lsb] is a pure sign extension (all zeros or all ones).
    function automatic logic upper_is_sext(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] hi;
        hi = $signed(v) >>> lsb;
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/immediate_pack_imm_pack_comb.sv
// Combinational field packer between S1 and S2; range check present only when
// IMM_RANGE_CHECK_EN is defined, otherwise imm_err is tied low.
module imm_pack_comb
    import immediate_pack_pkg::*;
(
    input  pack_req_t   req,
    output logic [31:0] instr,
    output logic        imm_err
);

    always_comb begin
        instr = '0;
        instr[6:0]            = req.opcode;
        instr[RD_LSB +: 5]    = req.rd;
        instr[F3_LSB +: 3]    = req.funct3;
        instr[RS1_LSB +: 5]   = req.rs1;
        case (req.sel)
            IMM_U: instr[31:12] = req.imm[31:12];
            IMM_I: instr[31:20] = req.imm[11:0];
            IMM_ISH: begin
                instr[31:25] = {1'b0, req.imm[10], 5'b0};
                instr[24:20] = req.imm[4:0];
            end
            IMM_S: begin
                instr[31:25]        = req.imm[11:5];
                instr[RS2_LSB +: 5] = req.rs2;
                instr[11:7]         = req.imm[4:0];
            end
            IMM_B: begin
                instr[31]           = req.imm[12];
                instr[30:25]        = req.imm[10:5];
                instr[RS2_LSB +: 5] = req.rs2;
                instr[11:8]         = req.imm[4:1];
                instr[7]            = req.imm[11];
            end
            IMM_J: begin
                instr[31]    = req.imm[20];
                instr[30:21] = req.imm[10:1];
                instr[20]    = req.imm[11];
                instr[19:12] = req.imm[19:12];
            end
            IMM_R: begin
                instr[F7_LSB +: 7]  = req.funct7;
                instr[RS2_LSB +: 5] = req.rs2;
            end
            default: instr = NOP_INSTR;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        imm_err = 1'b0;
        case (req.sel)
            IMM_U:        imm_err = |req.imm[11:0];
            IMM_I, IMM_S: imm_err = !upper_is_sext(req.imm, 11);
            IMM_ISH:      imm_err = (|req.imm[31:11]) | (|req.imm[9:5]);
            IMM_B:        imm_err = !upper_is_sext(req.imm, 12) | req.imm[0];
            IMM_J:        imm_err = !upper_is_sext(req.imm, 20) | req.imm[0];
            IMM_R:        imm_err = 1'b0;
            default:      imm_err = 1'b1;
        endcase
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: rtl/immediate_pack.sv
// Two-stage elastic RV32IM instruction packer (S1 raw fields, S2 packed word).
// Define IMM_RANGE_CHECK_EN to enable the immediate representability check on imm_err.
module immediate_pack
    import immediate_pack_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         imm_select,
    input  logic [31:0]        imm_value,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        instr,
    output logic               imm_err,
    output logic [COUNT_W-1:0] enc_count
);

    // vld_pipe bit 0 = S1 occupied, bit 1 = S2 occupied
    logic [1:0]         vld_pipe_q, vld_pipe_d;
    pack_req_t          s1_req_q, s1_req_d;
    logic [31:0]        instr_q, instr_d;
    logic               imm_err_q, imm_err_d;
    logic [COUNT_W-1:0] enc_count_q, enc_count_d;

    logic [31:0] pack_instr;
    logic        pack_err;
    logic        s2_open, s1_advance, in_fire, out_fire;

    imm_pack_comb u_pack (
        .req     (s1_req_q),
        .instr   (pack_instr),
        .imm_err (pack_err)
    );

    always_comb begin
        out_fire   = vld_pipe_q[1] && out_ready;
        s2_open    = !vld_pipe_q[1] || out_ready;
        s1_advance = vld_pipe_q[0] && s2_open;
        in_ready   = !vld_pipe_q[0] || s1_advance;
        in_fire    = in_valid && in_ready;

        vld_pipe_d  = vld_pipe_q;
        s1_req_d    = s1_req_q;
        instr_d     = instr_q;
        imm_err_d   = imm_err_q;
        enc_count_d = enc_count_q;

        if (out_fire) vld_pipe_d[1] = 1'b0;
        if (s1_advance) begin
            vld_pipe_d[1] = 1'b1;
            vld_pipe_d[0] = 1'b0;
            instr_d       = pack_instr;
            imm_err_d     = pack_err;
        end
        if (in_fire) begin
            vld_pipe_d[0] = 1'b1;
            s1_req_d = '{sel: imm_select, imm: imm_value, opcode: opcode, rd: rd,
                         rs1: rs1, rs2: rs2, funct3: funct3, funct7: funct7};
        end
        if (out_fire && enc_count_q != '1) enc_count_d = enc_count_q + COUNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q  <= '0;
            s1_req_q    <= '0;
            instr_q     <= '0;
            imm_err_q   <= 1'b0;
            enc_count_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            s1_req_q    <= s1_req_d;
            instr_q     <= instr_d;
            imm_err_q   <= imm_err_d;
            enc_count_q <= enc_count_d;
        end
    end

    assign out_valid = vld_pipe_q[1];
    assign instr     = instr_q;
    assign imm_err   = imm_err_q;
    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_immediate_pack.sv
// Self-checking bench for immediate_pack: directed vectors, backpressure, random traffic
// against a queue-based reference model with extender round-trip, and async reset.
module tb_immediate_pack;
    import immediate_pack_pkg::*;

    localparam int CW = 4;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [2:0]    imm_select = '0;
    logic [31:0]   imm_value = '0;
    logic [6:0]    opcode = '0, funct7 = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]    funct3 = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [31:0]   instr;
    logic          imm_err;
    logic [CW-1:0] enc_count;

    immediate_pack #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm_select(imm_select), .imm_value(imm_value), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .imm_err(imm_err), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel; logic [31:0] imm; logic [6:0] op;
        logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7; bit rt;
    } fld_t;
    typedef struct { logic [31:0] instr; logic err; bit rt; logic [2:0] sel; logic [31:0] imm; } exp_t;

    exp_t exp_q[$];
    int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0, out_hs = 0;
    logic last_ov, last_ir, last_err;
    logic [31:0] last_instr;
    logic stall_prev = 1'b0, stall_err;
    logic [31:0] stall_instr;
    fld_t idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic fld_t mk(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                                input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                                input logic [2:0] f3);
        fld_t f;
        f.sel = sel; f.imm = imm; f.op = op; f.rd = rd_i; f.rs1 = rs1_i; f.rs2 = rs2_i;
        f.f3 = f3; f.f7 = '0; f.rt = 1'b0;
        return f;
    endfunction

    // Reference: instruction layouts written out as whole-word concatenations.
    function automatic logic [31:0] model_instr(input fld_t f);
        logic [31:0] i;
        case (f.sel)
            3'd0: i = {f.imm[31:12], f.rd, f.op};
            3'd1: i = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
            3'd2: i = {1'b0, f.imm[10], 5'b0, f.imm[4:0], f.rs1, f.f3, f.rd, f.op};
            3'd3: i = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
            3'd4: i = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], f.op};
            3'd5: i = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
            3'd6: i = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
            default: i = 32'h0000_0013;
        endcase
        return i;
    endfunction

    // Reference: representability as signed-range / alignment arithmetic.
    function automatic logic model_err(input fld_t f);
        int v;
        v = $signed(f.imm);
        if (!CHK_ON) return 1'b0;
        case (f.sel)
            3'd0:       return (f.imm % 32'd4096) != 0;
            3'd1, 3'd3: return !(v >= -2048 && v <= 2047);
            3'd2:       return (f.imm & ~32'h0000_041F) != 0;
            3'd4:       return !(v >= -4096 && v <= 4095) || (v % 2 != 0);
            3'd5:       return !(v >= -(1 << 20) && v < (1 << 20)) || (v % 2 != 0);
            3'd6:       return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    // Standard RV32 immediate extender, used to close the round trip.
    function automatic logic [31:0] extend(input logic [2:0] sel, input logic [31:0] i);
        case (sel)
            3'd0:       return {i[31:12], 12'b0};
            3'd1, 3'd2: return {{20{i[31]}}, i[31:20]};
            3'd3:       return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd4:       return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd5:       return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:    return 32'h0;
        endcase
    endfunction

    function automatic fld_t rand_fld();
        fld_t f;
        logic [31:0] r;
        r = $urandom;
        f.sel = 3'($urandom_range(0, 7));
        f.op = 7'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom); f.f3 = 3'($urandom); f.f7 = 7'($urandom);
        f.rt = ($urandom_range(0, 3) != 0);
        if (f.rt) begin
            case (f.sel)
                3'd0:       f.imm = r & 32'hFFFF_F000;
                3'd1, 3'd3: f.imm = {{20{r[11]}}, r[11:0]};
                3'd2:       f.imm = {21'b0, r[10], 5'b0, r[4:0]};
                3'd4:       f.imm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd5:       f.imm = {{11{r[20]}}, r[20:1], 1'b0};
                default:    f.imm = r;
            endcase
        end else begin
            f.imm = r;
        end
        f.rt = f.rt && (f.sel >= 3'd1) && (f.sel <= 3'd5);
        return f;
    endfunction

    // One clock: drive at negedge, sample 1ns later, score handshakes, then wait for posedge.
    task automatic tick(input logic iv, input fld_t f, input logic ordy);
        exp_t e;
        logic [31:0] x;
        @(negedge clk);
        in_valid = iv; imm_select = f.sel; imm_value = f.imm; opcode = f.op;
        rd = f.rd; rs1 = f.rs1; rs2 = f.rs2; funct3 = f.f3; funct7 = f.f7; out_ready = ordy;
        #1;
        last_ov = out_valid; last_ir = in_ready; last_instr = instr; last_err = imm_err;
        check("enc_count", 32'(enc_count), (out_hs > 15) ? 32'd15 : 32'(out_hs));
        if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_instr", instr, stall_instr);
            check("hold_err", 32'(imm_err), 32'(stall_err));
        end
        stall_prev = out_valid && !out_ready;
        stall_instr = instr; stall_err = imm_err;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("instr", instr, e.instr);
                check("imm_err", 32'(imm_err), 32'(e.err));
                if (e.rt) begin
                    x = extend(e.sel, instr);
                    if (e.sel == 3'd2) check("rt_shift", 32'({x[10], x[4:0]}), 32'({e.imm[10], e.imm[4:0]}));
                    else check("round_trip", x, e.imm);
                end
            end
            out_hs++;
        end
        if (iv && in_ready) begin
            e.instr = model_instr(f); e.err = model_err(f); e.rt = f.rt; e.sel = f.sel; e.imm = f.imm;
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic one(input string tag, input fld_t f, input logic [31:0] ei, input logic ee);
        tick(1'b1, f, 1'b1);  check({tag, "_accept"}, 32'(last_ir), 32'd1);
        tick(1'b0, idle, 1'b1); check({tag, "_lat1"}, 32'(last_ov), 32'd0);
        tick(1'b0, idle, 1'b1); check({tag, "_lat2"}, 32'(last_ov), 32'd1);
        check({tag, "_instr"}, last_instr, ei);
        check({tag, "_err"}, 32'(last_err), 32'(ee));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            tick(1'b0, idle, 1'b1);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fld_t bp[5];
        int k, c, hs0;
        bit saw_stall;

        idle = mk(3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0);

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_imm_err", 32'(imm_err), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Backpressure: 5 back-to-back inputs, out_ready low on cycles 2..4
        for (int i = 0; i < 5; i++) bp[i] = rand_fld();
        k = 0; c = 0; saw_stall = 1'b0; hs0 = out_hs;
        while ((k < 5 || exp_q.size() > 0) && c < 40) begin
            tick(k < 5, bp[(k < 5) ? k : 0], !(c >= 2 && c <= 4));
            if (k < 5) begin
                if (last_ir) k++;
                else saw_stall = 1'b1;
            end
            c++;
        end
        check("bp_in_ready_drop", 32'(saw_stall), 32'd1);
        check("bp_outputs", 32'(out_hs - hs0), 32'd5);
        #1;
        check("bp_enc_count", 32'(enc_count), 32'd5);

        // Directed vectors
        one("I", mk(IMM_I, 32'hFFFF_F800, 7'h13, 5'd5, 5'd2, 5'd0, 3'd0), 32'h8001_0293, 1'b0);
        one("B", mk(IMM_B, 32'h0000_0FFE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0), 32'h7E20_8FE3, 1'b0);
        one("B_odd", mk(IMM_B, 32'h0000_0003, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0), 32'h0020_8163, CHK_ON);
        one("J", mk(IMM_J, 32'h0010_0000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0), 32'h8000_00EF, CHK_ON);
        one("ILL", mk(IMM_ILLEGAL, 32'h1234_5678, 7'h33, 5'd7, 5'd8, 5'd9, 3'd1), 32'h0000_0013, CHK_ON);

        // Random traffic with random backpressure; counter saturates along the way
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, rand_fld(), $urandom_range(0, 3) != 0);
        drain();
        #1;
        check("enc_saturated", 32'(enc_count), 32'd15);

        // Async reset with both stages full
        tick(1'b1, rand_fld(), 1'b0);
        tick(1'b1, rand_fld(), 1'b0);
        #2;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_enc_count", 32'(enc_count), 32'd0);
        check("arst_instr", instr, 32'h0);
        exp_q.delete();
        out_hs = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, idle, 1'b1);
            check("no_stale_out", 32'(last_ov), 32'd0);
        end
        check("post_rst_in_ready", 32'(last_ir), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
